// File: rtl/psum_drain_if.sv
// Bundle of the psum-row input, serialized-word output and buffer status
// signals of psum_drain. The slave view is the drain block itself; the
// master view is the surrounding logic (array bottom row plus consumer).
interface psum_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COLS   = 8
);
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  logic                           i_psum_valid;
  logic [NUM_COLS*DATA_WIDTH-1:0] i_psum;
  logic                           i_last_pass;
  logic                           i_ready;
  logic [DATA_WIDTH-1:0]          o_data;
  logic [COL_W-1:0]               o_col;
  logic                           o_valid;
  logic                           o_last;
  logic                           o_full;
  logic                           o_empty;
  logic                           o_overflow;

  modport slave (
    input  i_psum_valid, i_psum, i_last_pass, i_ready,
    output o_data, o_col, o_valid, o_last, o_full, o_empty, o_overflow
  );

  modport master (
    output i_psum_valid, i_psum, i_last_pass, i_ready,
    input  o_data, o_col, o_valid, o_last, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/psum_drain.sv
// Partial-sum drain: accumulates psum rows per column across passes, stores
// each finished row in a small circular row buffer and serializes the head
// row one column word at a time over a valid/ready handshake.
// ROW_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// The interface instance must be built with the same DATA_WIDTH/NUM_COLS.
module psum_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COLS   = 8,
  parameter int ROW_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rest,
  psum_drain_if.slave bus
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PTR_W = $clog2(ROW_DEPTH);
  localparam int ROW_W = NUM_COLS * DATA_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(ROW_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W + 1)'(1);

  logic [ROW_W-1:0]      row_sum;
  logic [ROW_W-1:0]      mem [ROW_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic [PTR_W:0]        count_reg;
  logic [PTR_W:0]        count_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  overflow_reg;

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic [COL_W-1:0]      col_reg;
  logic [COL_W-1:0]      col_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;

  logic                  push_req;
  logic                  push_ok;
  logic                  handshake;
  logic                  pop;

  // Select one column word out of a stored row.
  function automatic logic [DATA_WIDTH-1:0] word_at(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col == COL_W'(c)) w = row[c*DATA_WIDTH +: DATA_WIDTH];
    end
    return w;
  endfunction

  // Per-column accumulators; the final-pass sum feeds the row buffer directly
  // so a finished row costs no extra cycle, and the accumulator restarts at 0.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    logic [DATA_WIDTH-1:0] acc_reg;
    logic [DATA_WIDTH-1:0] sum;

    assign sum = acc_reg + bus.i_psum[gi*DATA_WIDTH +: DATA_WIDTH];
    assign row_sum[gi*DATA_WIDTH +: DATA_WIDTH] = sum;

    // Accumulate every valid pass, clear on the final one.
    always_ff @(posedge i_clk) begin
      if (i_rest) begin
        acc_reg <= '0;
      end else if (bus.i_psum_valid) begin
        acc_reg <= bus.i_last_pass ? '0 : sum;
      end
    end
  end

  // Push/pop decisions: a push into a full buffer only succeeds when the
  // head row leaves on the same edge, otherwise the row is dropped.
  always_comb begin
    push_req   = bus.i_psum_valid && bus.i_last_pass && !i_rest;
    handshake  = (state_reg == ST_SEND) && bus.i_ready;
    pop        = handshake && (col_reg == LAST_COL);
    push_ok    = push_req && (!full_reg || pop);
    count_next = count_reg + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
    rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
  end

  // Row buffer storage, written with the completed row.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= row_sum;
    end
  end

  // Drain sequencing. The output word is registered, so the next word is
  // read from the buffer here. Staying in SEND after a pop is only done when
  // a second row was already stored; a row written on that same edge is
  // picked up from IDLE one cycle later, which avoids a write-to-read bypass.
  always_comb begin
    state_next  = state_reg;
    col_next    = col_reg;
    data_next   = data_reg;
    rd_ptr_next = rd_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!empty_reg) begin
          state_next = ST_SEND;
          col_next   = '0;
          data_next  = word_at(mem[rd_ptr_reg], '0);
        end
      end
      ST_SEND: begin
        if (bus.i_ready) begin
          if (col_reg == LAST_COL) begin
            rd_ptr_next = rd_ptr_inc;
            col_next    = '0;
            if (count_reg > ONE_CNT) begin
              data_next = word_at(mem[rd_ptr_inc], '0);
            end else begin
              state_next = ST_IDLE;
              data_next  = '0;
            end
          end else begin
            col_next  = col_reg + COL_W'(1);
            data_next = word_at(mem[rd_ptr_reg], col_reg + COL_W'(1));
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        col_next   = '0;
        data_next  = '0;
      end
    endcase
  end

  // FSM, pointer, occupancy and status registers.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      state_reg    <= ST_IDLE;
      col_reg      <= '0;
      data_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      col_reg    <= col_next;
      data_reg   <= data_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == DEPTH_CNT);
      empty_reg  <= (count_next == '0);
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.o_valid    = (state_reg == ST_SEND);
  assign bus.o_last     = (state_reg == ST_SEND) && (col_reg == LAST_COL);
  assign bus.o_data     = data_reg;
  assign bus.o_col      = col_reg;
  assign bus.o_full     = full_reg;
  assign bus.o_empty    = empty_reg;
  assign bus.o_overflow = overflow_reg;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with NUM_COLS=4, ROW_DEPTH=2, DATA_WIDTH=32.
module tb_psum_drain;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  psum_drain_if #(.DATA_WIDTH(32), .NUM_COLS(4)) bus ();

  psum_drain #(.DATA_WIDTH(32), .NUM_COLS(4), .ROW_DEPTH(2)) dut (
    .i_clk (clk),
    .i_rest(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input logic [31:0] c0, c1, c2, c3, input logic last);
    bus.i_psum_valid = 1'b1;
    bus.i_psum       = {c3, c2, c1, c0};
    bus.i_last_pass  = last;
  endtask

  task automatic idle_inputs();
    bus.i_psum_valid = 1'b0;
    bus.i_psum       = '0;
    bus.i_last_pass  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i_ready = 1'b0;
    apply_reset();
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    vectors++; if (bus.o_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got=%b exp=0", bus.o_last); end
    vectors++; if (bus.o_data !== 32'd0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", bus.o_data); end
    vectors++; if (bus.o_col !== 2'd0) begin miscompares++; $display("FAIL reset_col got=%0d exp=0", bus.o_col); end
    vectors++; if (bus.o_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", bus.o_empty); end
    vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", bus.o_overflow); end
  endtask

  // Three passes of {1,2,3,4} -> 3,6,9,12.
  task automatic test_accumulate();
    logic [31:0] exp_w [4] = '{32'd3, 32'd6, 32'd9, 32'd12};
    bus.i_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drive_row(32'd1, 32'd2, 32'd3, 32'd4, p == 2);
      tick();
    end
    idle_inputs();
    vectors++; if (bus.o_empty !== 1'b0) begin miscompares++; $display("FAIL acc_empty_after_push got=%b exp=0", bus.o_empty); end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL acc_valid_latency got=%b exp=0", bus.o_valid); end
    tick();
    for (int c = 0; c < 4; c++) begin
      $display("tx acc col=%0d data=%0d last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_valid !== 1'b1) begin miscompares++; $display("FAIL acc_valid c=%0d got=%b exp=1", c, bus.o_valid); end
      vectors++; if (bus.o_data !== exp_w[c]) begin miscompares++; $display("FAIL acc_data c=%0d got=%0d exp=%0d", c, bus.o_data, exp_w[c]); end
      vectors++; if (bus.o_col !== 2'(c)) begin miscompares++; $display("FAIL acc_col got=%0d exp=%0d", bus.o_col, c); end
      vectors++; if (bus.o_last !== (c == 3)) begin miscompares++; $display("FAIL acc_last c=%0d got=%b exp=%b", c, bus.o_last, c == 3); end
      tick();
    end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL acc_idle_valid got=%b exp=0", bus.o_valid); end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL acc_idle_empty got=%b exp=1", bus.o_empty); end
  endtask

  // 0xFFFFFFFF + 2 wraps to 1 in column 0.
  task automatic test_wrap();
    logic [31:0] exp_w [4] = '{32'h1, 32'h7, 32'h0, 32'h80000000};
    bus.i_ready = 1'b1;
    drive_row(32'hFFFFFFFF, 32'h5, 32'h0, 32'h7FFFFFFF, 1'b0);
    tick();
    drive_row(32'h00000002, 32'h2, 32'h0, 32'h00000001, 1'b1);
    tick();
    idle_inputs();
    tick();
    for (int c = 0; c < 4; c++) begin
      $display("tx wrap col=%0d data=%h last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_data !== exp_w[c]) begin miscompares++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, bus.o_data, exp_w[c]); end
      tick();
    end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_idle_valid got=%b exp=0", bus.o_valid); end
  endtask

  // Hold i_ready low for 5 cycles with o_valid up.
  task automatic test_stall();
    bus.i_ready = 1'b0;
    drive_row(32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
    tick();
    idle_inputs();
    tick();
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.o_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid k=%0d got=%b exp=1", k, bus.o_valid); end
      vectors++; if (bus.o_data !== 32'd5) begin miscompares++; $display("FAIL stall_data k=%0d got=%0d exp=5", k, bus.o_data); end
      vectors++; if (bus.o_col !== 2'd0) begin miscompares++; $display("FAIL stall_col k=%0d got=%0d exp=0", k, bus.o_col); end
      tick();
    end
    bus.i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      $display("tx stall col=%0d data=%0d last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_data !== 32'(5 + c)) begin miscompares++; $display("FAIL stall_drain c=%0d got=%0d exp=%0d", c, bus.o_data, 5 + c); end
      tick();
    end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL stall_empty got=%b exp=1", bus.o_empty); end
  endtask

  // Three rows into a 2-deep buffer with no draining: third row is dropped.
  task automatic test_overflow();
    logic [31:0] exp_w [8] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd20, 32'd21, 32'd22, 32'd23};
    bus.i_ready = 1'b0;
    drive_row(32'd10, 32'd11, 32'd12, 32'd13, 1'b1);
    tick();
    vectors++; if (bus.o_full !== 1'b0) begin miscompares++; $display("FAIL ovf_full_row1 got=%b exp=0", bus.o_full); end
    drive_row(32'd20, 32'd21, 32'd22, 32'd23, 1'b1);
    tick();
    vectors++; if (bus.o_full !== 1'b1) begin miscompares++; $display("FAIL ovf_full_row2 got=%b exp=1", bus.o_full); end
    vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got=%b exp=0", bus.o_overflow); end
    drive_row(32'd30, 32'd31, 32'd32, 32'd33, 1'b1);
    tick();
    idle_inputs();
    vectors++; if (bus.o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", bus.o_overflow); end
    vectors++; if (bus.o_full !== 1'b1) begin miscompares++; $display("FAIL ovf_full_row3 got=%b exp=1", bus.o_full); end
    bus.i_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      $display("tx ovf col=%0d data=%0d last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid w=%0d got=%b exp=1", w, bus.o_valid); end
      vectors++; if (bus.o_data !== exp_w[w]) begin miscompares++; $display("FAIL ovf_data w=%0d got=%0d exp=%0d", w, bus.o_data, exp_w[w]); end
      tick();
    end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_no_row3 got=%b exp=0", bus.o_valid); end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty got=%b exp=1", bus.o_empty); end
    vectors++; if (bus.o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
  endtask

  // Full buffer, final-pass push on the same edge as the last-word handshake.
  task automatic test_full_pop_push();
    logic [31:0] exp_w [8] = '{32'd200, 32'd201, 32'd202, 32'd203, 32'd300, 32'd301, 32'd302, 32'd303};
    bus.i_ready = 1'b0;
    apply_reset();
    vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_ovf_cleared got=%b exp=0", bus.o_overflow); end
    drive_row(32'd100, 32'd101, 32'd102, 32'd103, 1'b1);
    tick();
    drive_row(32'd200, 32'd201, 32'd202, 32'd203, 1'b1);
    tick();
    idle_inputs();
    bus.i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vectors++; if (bus.o_data !== 32'(100 + c)) begin miscompares++; $display("FAIL fpp_row1 c=%0d got=%0d exp=%0d", c, bus.o_data, 100 + c); end
      tick();
    end
    vectors++; if (bus.o_last !== 1'b1) begin miscompares++; $display("FAIL fpp_row1_last got=%b exp=1", bus.o_last); end
    drive_row(32'd300, 32'd301, 32'd302, 32'd303, 1'b1);
    tick();
    idle_inputs();
    vectors++; if (bus.o_full !== 1'b1) begin miscompares++; $display("FAIL fpp_full got=%b exp=1", bus.o_full); end
    vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow got=%b exp=0", bus.o_overflow); end
    for (int w = 0; w < 8; w++) begin
      $display("tx fpp col=%0d data=%0d last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_data !== exp_w[w]) begin miscompares++; $display("FAIL fpp_data w=%0d got=%0d exp=%0d", w, bus.o_data, exp_w[w]); end
      vectors++; if (bus.o_col !== 2'(w % 4)) begin miscompares++; $display("FAIL fpp_col w=%0d got=%0d exp=%0d", w, bus.o_col, w % 4); end
      tick();
    end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL fpp_empty got=%b exp=1", bus.o_empty); end
  endtask

  // Reset while o_col=2 with a partial row accumulating.
  task automatic test_reset_mid_drain();
    bus.i_ready = 1'b1;
    drive_row(32'd7, 32'd8, 32'd9, 32'd10, 1'b1);
    tick();
    drive_row(32'd50, 32'd50, 32'd50, 32'd50, 1'b0);
    tick();
    idle_inputs();
    tick();
    tick();
    vectors++; if (bus.o_col !== 2'd2) begin miscompares++; $display("FAIL rmd_col_before got=%0d exp=2", bus.o_col); end
    rst = 1'b1;
    drive_row(32'd60, 32'd60, 32'd60, 32'd60, 1'b1);
    tick();
    rst = 1'b0;
    idle_inputs();
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL rmd_valid got=%b exp=0", bus.o_valid); end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL rmd_empty got=%b exp=1", bus.o_empty); end
    vectors++; if (bus.o_col !== 2'd0) begin miscompares++; $display("FAIL rmd_col got=%0d exp=0", bus.o_col); end
    tick();
    tick();
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL rmd_quiet got=%b exp=0", bus.o_valid); end
    drive_row(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    tick();
    idle_inputs();
    tick();
    for (int c = 0; c < 4; c++) begin
      $display("tx rmd col=%0d data=%0d last=%b", bus.o_col, bus.o_data, bus.o_last);
      vectors++; if (bus.o_col !== 2'(c)) begin miscompares++; $display("FAIL rmd_new_col got=%0d exp=%0d", bus.o_col, c); end
      vectors++; if (bus.o_data !== 32'(c + 1)) begin miscompares++; $display("FAIL rmd_new_data c=%0d got=%0d exp=%0d", c, bus.o_data, c + 1); end
      tick();
    end
    vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL rmd_final_empty got=%b exp=1", bus.o_empty); end
  endtask

  initial begin
    idle_inputs();
    bus.i_ready = 1'b0;
    test_reset();
    test_accumulate();
    test_wrap();
    test_stall();
    test_overflow();
    test_full_pop_push();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
